// File: rtl/psum_ofifo.sv
// Per-column psum output FIFO: independent lanes, whole-row first-word-fall-through pop.
// Optional sticky overflow flag and drop report under `define PSUM_OFIFO_OVF_EN.
module psum_ofifo #(
  parameter int col     = 8,
  parameter int bw_psum = 19,
  parameter int depth   = 16,
  parameter int adepth  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*bw_psum-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*bw_psum-1:0] out,
  output logic                   o_valid,
  output logic                   o_ready,
  output logic                   o_full,
  output logic                   o_ovf
);

  localparam logic [adepth:0] PTR_ONE = (adepth+1)'(1);

  logic [bw_psum-1:0] mem    [col][depth];
  logic [adepth:0]    wr_ptr [col];
  logic [adepth:0]    rd_ptr [col];
  logic [col-1:0]     empty;
  logic [col-1:0]     full;
  logic [col-1:0]     wr_en;
  logic               pop;

  always_comb begin
    empty = '0;
    full  = '0;
    out   = '0;
    for (int unsigned i = 0; i < col; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][adepth] != rd_ptr[i][adepth]) &&
                 (wr_ptr[i][adepth-1:0] == rd_ptr[i][adepth-1:0]);
      if (!empty[i])
        out[i*bw_psum +: bw_psum] = mem[i][rd_ptr[i][adepth-1:0]];
    end
  end

  assign o_valid = ~|empty;
  assign o_ready = ~|full;
  assign o_full  = |full;
  assign pop     = rd & o_valid;

  // A pop frees a slot on the same edge, so a full lane may still accept a write.
  always_comb begin
    wr_en = '0;
    for (int unsigned i = 0; i < col; i++)
      wr_en[i] = wr[i] & (~full[i] | pop);
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < col; i++)
      if (wr_en[i])
        mem[i][wr_ptr[i][adepth-1:0]] <= in[i*bw_psum +: bw_psum];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < col; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < col; i++) begin
        if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
        if (pop)      rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
      end
    end
  end

`ifdef PSUM_OFIFO_OVF_EN
  logic [col-1:0] drop;
  logic           ovf_q;

  assign drop = wr & full & {col{~pop}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      ovf_q <= 1'b0;
    else if (|drop) ovf_q <= 1'b1;
  end

  assign o_ovf = ovf_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset)
      for (int unsigned i = 0; i < col; i++)
        if (drop[i]) $display("psum_ofifo: write dropped on full lane %0d", i);
  end
`endif
`else
  assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_psum_ofifo.sv
// Scoreboard bench for psum_ofifo: stimulus queues expected rows, a monitor checks every pop.
module tb_psum_ofifo;

  localparam int COL = 8;
  localparam int BW  = 19;
  localparam int W   = COL*BW;

`ifdef PSUM_OFIFO_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic           clk;
  logic           reset;
  logic [W-1:0]   in;
  logic [COL-1:0] wr;
  logic           rd;
  logic [W-1:0]   out;
  logic           o_valid;
  logic           o_ready;
  logic           o_full;
  logic           o_ovf;

  int n_pass  = 0;
  int n_total = 0;
  logic [W-1:0] exp_q [$];

  psum_ofifo #(.col(COL), .bw_psum(BW), .depth(16), .adepth(4)) dut (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .out(out),
    .o_valid(o_valid), .o_ready(o_ready), .o_full(o_full), .o_ovf(o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mkrow(input int v);
    logic [W-1:0] r;
    logic [31:0]  t;
    t = v;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = t[BW-1:0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%h exp=%h", name, act, exp);
  endtask

  // Inputs are held across one rising edge, then returned to idle.
  task automatic step();
    @(posedge clk);
    #1;
    wr = '0;
    rd = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: every accepted pop must present the next queued row.
  always @(negedge clk) begin
    if (!reset && rd && o_valid) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL pop_unexpected act=%h exp=none", out);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (out === e) n_pass++;
        else $display("FAIL pop_row act=%h exp=%h", out, e);
      end
    end
  end

  initial begin
    logic [W-1:0] skew;
    logic         saw_full;
    logic         lost_valid;
    reset = 1'b1; in = '0; wr = '0; rd = 1'b0;
    #12;

    // 1: skewed fill
    do_reset();
    chk("rst_valid", W'(o_valid), W'(0));
    chk("rst_ready", W'(o_ready), W'(1));
    chk("rst_full",  W'(o_full),  W'(0));
    chk("rst_ovf",   W'(o_ovf),   W'(0));
    chk("rst_out",   out,         '0);
    for (int i = 0; i < COL; i++) skew[i*BW +: BW] = BW'(100 + i);
    for (int i = 0; i < COL; i++) begin
      in = skew;
      wr = COL'(1) << i;
      step();
      chk($sformatf("skew_valid_%0d", i), W'(o_valid), W'(i == COL-1));
    end
    exp_q.push_back(skew);
    rd = 1'b1;
    step();
    chk("skew_after_pop_valid", W'(o_valid), W'(0));

    // 2: fill to full, dropped write, drain in order
    do_reset();
    for (int r = 1; r <= 16; r++) begin
      in = mkrow(r); wr = '1;
      exp_q.push_back(mkrow(r));
      step();
      if (r == 15) chk("fill15_ready", W'(o_ready), W'(1));
    end
    chk("fill16_full",  W'(o_full),  W'(1));
    chk("fill16_ready", W'(o_ready), W'(0));
    chk("fill16_ovf",   W'(o_ovf),   W'(0));
    in = mkrow(555); wr = '1;
    step();
    chk("drop_ovf",  W'(o_ovf),  W'(OVF_ON));
    chk("drop_full", W'(o_full), W'(1));
    for (int r = 0; r < 16; r++) begin
      rd = 1'b1;
      step();
    end
    chk("drain_valid", W'(o_valid), W'(0));
    chk("drain_ovf",   W'(o_ovf),   W'(OVF_ON));

    // 3: full lane 0 with simultaneous write and pop
    do_reset();
    for (int r = 1; r <= 16; r++) begin
      in = mkrow(200 + r); wr = '1;
      exp_q.push_back(mkrow(200 + r));
      step();
    end
    in = mkrow(777); wr = 8'h01; rd = 1'b1;
    step();
    chk("wp_full_lane0", W'(o_full), W'(1));
    chk("wp_full_ovf",   W'(o_ovf),  W'(0));
    for (int r = 0; r < 15; r++) begin
      rd = 1'b1;
      step();
    end
    chk("wp_full_valid", W'(o_valid), W'(0));
    chk("wp_full_head0", W'(out[BW-1:0]), W'(BW'(777)));
    chk("wp_full_nofull", W'(o_full), W'(0));

    // 4: single entry, write and pop together
    do_reset();
    in = mkrow(-5); wr = '1;
    exp_q.push_back(mkrow(-5));
    step();
    chk("one_valid", W'(o_valid), W'(1));
    chk("one_out",   out,         mkrow(-5));
    in = mkrow(42); wr = '1; rd = 1'b1;
    exp_q.push_back(mkrow(42));
    step();
    chk("one_next_out",   out,         mkrow(42));
    chk("one_next_valid", W'(o_valid), W'(1));
    rd = 1'b1;
    step();
    chk("one_drain_valid", W'(o_valid), W'(0));

    // 5: streaming across pointer wrap
    do_reset();
    in = mkrow(1000); wr = '1;
    exp_q.push_back(mkrow(1000));
    step();
    saw_full = 1'b0;
    lost_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      in = mkrow(1000 + k); wr = '1; rd = 1'b1;
      exp_q.push_back(mkrow(1000 + k));
      step();
      saw_full   |= o_full;
      lost_valid |= ~o_valid;
    end
    chk("wrap_never_full", W'(saw_full),   W'(0));
    chk("wrap_kept_valid", W'(lost_valid), W'(0));
    chk("wrap_ovf",        W'(o_ovf),      W'(0));
    rd = 1'b1;
    step();
    chk("wrap_drain_valid", W'(o_valid), W'(0));

    // 6: asynchronous reset with 5 rows stored
    do_reset();
    for (int r = 0; r < 5; r++) begin
      in = mkrow(300 + r); wr = '1;
      step();
    end
    chk("ar_pre_valid", W'(o_valid), W'(1));
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_valid", W'(o_valid), W'(0));
    chk("ar_full",  W'(o_full),  W'(0));
    chk("ar_ovf",   W'(o_ovf),   W'(0));
    chk("ar_out",   out,         '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    in = mkrow(77); wr = '1;
    exp_q.push_back(mkrow(77));
    step();
    chk("ar_new_out",   out,         mkrow(77));
    chk("ar_new_valid", W'(o_valid), W'(1));
    rd = 1'b1;
    step();

    @(posedge clk);
    #1;
    chk("queue_empty", W'(exp_q.size()), W'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
